// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of Sig_In over a fixed gate
// window of Clk_50MHz cycles and latches the result as 4-digit packed BCD.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int GATE_W      = 26
) (
    input  logic        Clk_50MHz,
    input  logic        Reset,
    input  logic        Sig_In,
    output logic [15:0] Freq_BCD,
    output logic        Overflow,
    output logic        Valid,
    output logic        Gate_Tick
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Saturating packed-BCD increment; bit 16 flags an attempt to pass 9999.
    function automatic logic [16:0] bcdIncSat(input logic [15:0] bcd);
        logic [15:0] res;
        logic        carry;
        res   = bcd;
        carry = 1'b1;
        if (bcd == 16'h9999) begin
            return {1'b1, bcd};
        end
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return {1'b0, res};
    endfunction

    logic              sigMeta_p0;
    logic              sigSync_p1;
    logic              sigDly_p2;
    logic              edgeDet;
    logic [GATE_W-1:0] gateCnt;
    logic              terminal;
    logic [15:0]       runBcd;
    logic              runOvf;
    logic [16:0]       incRes;
    logic [15:0]       nextBcd;
    logic              nextOvf;

    // Stage p0..p2: two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            sigMeta_p0 <= 1'b0;
            sigSync_p1 <= 1'b0;
            sigDly_p2  <= 1'b0;
        end else begin
            sigMeta_p0 <= Sig_In;
            sigSync_p1 <= sigMeta_p0;
            sigDly_p2  <= sigSync_p1;
        end
    end

    assign edgeDet  = sigSync_p1 & ~sigDly_p2;
    assign terminal = (gateCnt == GATE_LAST);

    always_comb begin
        incRes  = bcdIncSat(runBcd);
        nextBcd = runBcd;
        nextOvf = runOvf;
        if (edgeDet) begin
            nextBcd = incRes[15:0];
            nextOvf = runOvf | incRes[16];
        end
    end

    // Gate timing runs independently of the input so a bad Sig_In cannot disturb it
    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            gateCnt <= '0;
        end else if (terminal) begin
            gateCnt <= '0;
        end else begin
            gateCnt <= gateCnt + GATE_W'(1);
        end
    end

    // Running count: on the terminal cycle the edge of that cycle is folded into
    // the latched result, and the next window starts clean at zero.
    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            runBcd <= '0;
            runOvf <= 1'b0;
        end else if (terminal) begin
            runBcd <= '0;
            runOvf <= 1'b0;
        end else begin
            runBcd <= nextBcd;
            runOvf <= nextOvf;
        end
    end

    // Result register: outputs only change together with the Valid pulse
    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            Freq_BCD  <= '0;
            Overflow  <= 1'b0;
            Valid     <= 1'b0;
            Gate_Tick <= 1'b0;
        end else begin
            Valid     <= terminal;
            Gate_Tick <= terminal;
            if (terminal) begin
                Freq_BCD <= nextBcd;
                Overflow <= nextOvf;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: seven instances with different gate lengths and input
// patterns run side by side; Valid events are logged and compared to a table.
module tb_freq_meter;

    localparam int ND     = 7;
    localparam int NLOG   = 8;
    localparam int END_N  = 80005;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        ov;
        logic        gt;
    } ev_t;

    typedef struct {
        int          dut;
        int          idx;
        int          cyc;
        logic [15:0] bcd;
        logic        ov;
    } vec_t;

    logic        clk;
    logic        rstAll;
    logic        rstF;
    logic        sig  [ND];
    logic [15:0] bcd  [ND];
    logic        ov   [ND];
    logic        vld  [ND];
    logic        gt   [ND];
    int          n;

    ev_t         evLog   [ND][NLOG];
    int          evCnt   [ND];
    int          unstable[ND];
    int          badBcd  [ND];
    int          tickDiff[ND];
    logic [15:0] lastBcd [ND];

    int passCnt;
    int totalCnt;

    // 0: period 10; 1: held 0; 2: held 1; 3: carry chain; 4: window boundary;
    // 5: mid-window reset; 6: overflow then recovery
    freq_meter #(.GATE_CYCLES(1000)) uA (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[0]),
        .Freq_BCD(bcd[0]), .Overflow(ov[0]), .Valid(vld[0]), .Gate_Tick(gt[0]));
    freq_meter #(.GATE_CYCLES(1000)) uB (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[1]),
        .Freq_BCD(bcd[1]), .Overflow(ov[1]), .Valid(vld[1]), .Gate_Tick(gt[1]));
    freq_meter #(.GATE_CYCLES(1000)) uC (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[2]),
        .Freq_BCD(bcd[2]), .Overflow(ov[2]), .Valid(vld[2]), .Gate_Tick(gt[2]));
    freq_meter #(.GATE_CYCLES(20000)) uD (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[3]),
        .Freq_BCD(bcd[3]), .Overflow(ov[3]), .Valid(vld[3]), .Gate_Tick(gt[3]));
    freq_meter #(.GATE_CYCLES(1000)) uE (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[4]),
        .Freq_BCD(bcd[4]), .Overflow(ov[4]), .Valid(vld[4]), .Gate_Tick(gt[4]));
    freq_meter #(.GATE_CYCLES(1000)) uF (
        .Clk_50MHz(clk), .Reset(rstAll | rstF), .Sig_In(sig[5]),
        .Freq_BCD(bcd[5]), .Overflow(ov[5]), .Valid(vld[5]), .Gate_Tick(gt[5]));
    freq_meter #(.GATE_CYCLES(40000)) uG (
        .Clk_50MHz(clk), .Reset(rstAll), .Sig_In(sig[6]),
        .Freq_BCD(bcd[6]), .Overflow(ov[6]), .Valid(vld[6]), .Gate_Tick(gt[6]));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // n = posedges since the last posedge that sampled the common reset
    always @(posedge clk) begin
        if (rstAll) n <= 0;
        else        n <= n + 1;
    end

    // A rise driven after posedge n is counted at gate position (n+2) mod GATE_CYCLES
    initial begin
        forever begin
            @(negedge clk);
            sig[0] = (n % 10) < 5;
            sig[1] = 1'b0;
            sig[2] = 1'b1;
            sig[3] = (n < 39980) ? ((n % 20) < 10) : 1'b0;
            sig[4] = (n >= 997 && n <= 1000) || (n >= 1998 && n <= 2001);
            sig[5] = (n % 10) < 5;
            sig[6] = (n < 40000) ? ((n % 4) < 2) : (((n - 40000) % 8) < 4);
        end
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            evCnt[d] = 0; unstable[d] = 0; badBcd[d] = 0; tickDiff[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rstAll) begin
                    if (vld[d]) begin
                        if (evCnt[d] < NLOG) begin
                            evLog[d][evCnt[d]].cyc = n;
                            evLog[d][evCnt[d]].bcd = bcd[d];
                            evLog[d][evCnt[d]].ov  = ov[d];
                            evLog[d][evCnt[d]].gt  = gt[d];
                        end
                        evCnt[d]++;
                    end else if (bcd[d] !== lastBcd[d]) begin
                        unstable[d]++;
                    end
                    if (gt[d] !== vld[d]) tickDiff[d]++;
                    for (int j = 0; j < 4; j++) begin
                        if (bcd[d][4*j +: 4] > 4'd9) badBcd[d]++;
                    end
                end
                lastBcd[d] = bcd[d];
            end
        end
    end

    task automatic check(input bit ok, input string name, input string act, input string req);
        totalCnt++;
        if (ok) passCnt++;
        else    $display("FAIL %s: got %s, required %s", name, act, req);
    endtask

    vec_t vecs[19];
    int   expCnt[ND];

    initial begin
        vecs[0]  = '{0, 0, 1000,  16'h0100, 1'b0};
        vecs[1]  = '{0, 1, 2000,  16'h0100, 1'b0};
        vecs[2]  = '{0, 2, 3000,  16'h0100, 1'b0};
        vecs[3]  = '{1, 0, 1000,  16'h0000, 1'b0};
        vecs[4]  = '{1, 1, 2000,  16'h0000, 1'b0};
        vecs[5]  = '{2, 0, 1000,  16'h0001, 1'b0};
        vecs[6]  = '{2, 1, 2000,  16'h0000, 1'b0};
        vecs[7]  = '{2, 2, 3000,  16'h0000, 1'b0};
        vecs[8]  = '{3, 0, 20000, 16'h1000, 1'b0};
        vecs[9]  = '{3, 1, 40000, 16'h0999, 1'b0};
        vecs[10] = '{3, 2, 60000, 16'h0000, 1'b0};
        vecs[11] = '{4, 0, 1000,  16'h0001, 1'b0};
        vecs[12] = '{4, 1, 2000,  16'h0000, 1'b0};
        vecs[13] = '{4, 2, 3000,  16'h0001, 1'b0};
        vecs[14] = '{4, 3, 4000,  16'h0000, 1'b0};
        vecs[15] = '{5, 0, 1371,  16'h0100, 1'b0};
        vecs[16] = '{5, 1, 2371,  16'h0100, 1'b0};
        vecs[17] = '{6, 0, 40000, 16'h9999, 1'b1};
        vecs[18] = '{6, 1, 80000, 16'h5000, 1'b0};
        expCnt   = '{80, 80, 80, 4, 80, 79, 2};

        passCnt  = 0;
        totalCnt = 0;
        rstAll   = 1'b1;
        rstF     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check(bcd[d] === 16'h0 && ov[d] === 1'b0 && vld[d] === 1'b0 && gt[d] === 1'b0,
                  $sformatf("reset_state[%0d]", d),
                  $sformatf("bcd=%h ov=%b vld=%b tick=%b", bcd[d], ov[d], vld[d], gt[d]),
                  "bcd=0000 ov=0 vld=0 tick=0");
        end
        rstAll = 1'b0;

        // One-cycle reset on instance 5 after 37 edges of the first window
        while (n != 370) @(negedge clk);
        rstF = 1'b1;
        @(negedge clk);
        rstF = 1'b0;
        check(bcd[5] === 16'h0 && ov[5] === 1'b0 && vld[5] === 1'b0 && gt[5] === 1'b0,
              "mid_reset_outputs",
              $sformatf("bcd=%h ov=%b vld=%b tick=%b", bcd[5], ov[5], vld[5], gt[5]),
              "bcd=0000 ov=0 vld=0 tick=0");

        while (n < END_N) @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            int d;
            int k;
            d = vecs[i].dut;
            k = vecs[i].idx;
            if (k >= evCnt[d]) begin
                check(1'b0, $sformatf("window[%0d.%0d]", d, k), "no Valid",
                      $sformatf("Valid at %0d", vecs[i].cyc));
            end else begin
                check(evLog[d][k].cyc == vecs[i].cyc && evLog[d][k].bcd === vecs[i].bcd &&
                      evLog[d][k].ov === vecs[i].ov && evLog[d][k].gt === 1'b1,
                      $sformatf("window[%0d.%0d]", d, k),
                      $sformatf("cyc=%0d bcd=%h ov=%b tick=%b", evLog[d][k].cyc,
                                evLog[d][k].bcd, evLog[d][k].ov, evLog[d][k].gt),
                      $sformatf("cyc=%0d bcd=%h ov=%b tick=1", vecs[i].cyc,
                                vecs[i].bcd, vecs[i].ov));
            end
        end

        for (int d = 0; d < ND; d++) begin
            check(evCnt[d] == expCnt[d], $sformatf("valid_count[%0d]", d),
                  $sformatf("%0d", evCnt[d]), $sformatf("%0d", expCnt[d]));
            check(unstable[d] == 0 && tickDiff[d] == 0 && badBcd[d] == 0,
                  $sformatf("stable_tick_bcd[%0d]", d),
                  $sformatf("unstable=%0d tickdiff=%0d badbcd=%0d", unstable[d],
                            tickDiff[d], badBcd[d]),
                  "all 0");
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
